// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or restoring-divide
// step per cycle, with a single-cycle path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, result_q, result_d;
  logic            is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic [1:0]      sel_q, sel_d;
  logic            busy_c, done_c;

  // operand decode for the op presented by EX
  logic            s1, s2, neg1, neg2, div0, ovf;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  always_comb begin
    s1       = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    s2       = op[2] ? ~op[0] : ~op[1];
    neg1     = s1 & rs1_data[XLEN-1];
    neg2     = s2 & rs2_data[XLEN-1];
    mag1     = neg1 ? -rs1_data : rs1_data;
    mag2     = neg2 ? -rs2_data : rs2_data;
    div0     = op[2] & (rs2_data == '0);
    ovf      = op[2] & ~op[0] & (rs1_data == MINV) & (&rs2_data);
    fast_res = div0 ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : MINV);
  end

  // one iteration: hi/lo hold product halves (mul) or remainder/quotient (div)
  logic [XLEN:0]     msum, trial;
  logic              qbit;
  logic [XLEN-1:0]   step_hi, step_lo, q_res, r_res, fin_res;
  logic [2*XLEN-1:0] prod, sprod;

  always_comb begin
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    trial = {hi_q, lo_q[XLEN-1]} - {1'b0, m_q};
    qbit  = ~trial[XLEN];
    if (is_div_q) begin
      step_hi = qbit ? trial[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      step_lo = {lo_q[XLEN-2:0], qbit};
    end else begin
      step_hi = msum[XLEN:1];
      step_lo = {msum[0], lo_q[XLEN-1:1]};
    end
    prod  = {step_hi, step_lo};
    sprod = neg_q ? -prod : prod;
    q_res = neg_q ? -step_lo : step_lo;
    r_res = rneg_q ? -step_hi : step_hi;
    if (is_div_q)
      fin_res = sel_q[1] ? r_res : q_res;
    else
      fin_res = (sel_q == 2'b00) ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    sel_d    = sel_q;
    result_d = result_q;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          busy_c   = 1'b1;
          cnt_d    = '0;
          is_div_d = op[2];
          sel_d    = op[1:0];
          neg_d    = neg1 ^ neg2;
          rneg_d   = neg1;
          hi_d     = '0;
          lo_d     = op[2] ? mag1 : mag2;
          m_d      = op[2] ? mag2 : mag1;
          if (div0 || ovf) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        busy_c = 1'b1;
        hi_d   = step_hi;
        lo_d   = step_lo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          result_d = fin_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a flush abandons any op in flight; a committed DONE still pulses
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      sel_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  // no stall is requested while reset is held
  assign busy   = busy_c & reset;
  assign done   = done_c;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic        busy, done;
  logic [31:0] result;
  int          ncmp = 0;
  int          nerr = 0;

  localparam logic [31:0] MINV = 32'h8000_0000;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      pa, pb;
    logic [63:0] pu;
    int          ia, ib;
    ia = a;
    ib = b;
    case (f)
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd1: begin pa = longint'($signed(a)); pb = longint'($signed(b)); pu = 64'(pa * pb); return pu[63:32]; end
      3'd2: begin pa = longint'($signed(a)); pb = longint'({32'b0, b}); pu = 64'(pa * pb); return pu[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic begin_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = f; rs1_data = a; rs2_data = b; start = 1'b1;
    #1;
    chk("busy_cycle0", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int lat, input logic [31:0] exp, input bit release_start);
    int cyc;
    bit busy_ok;
    cyc = 0;
    busy_ok = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc > 40) break;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_res"}, 64'(result), 64'(exp));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    if (release_start) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    begin_op(f, a, b);
    wait_done(tag, latency(f, a, b), exp, 1'b1);
  endtask

  initial begin
    logic [31:0] a, b, prior;
    logic [2:0]  f;
    reset = 1'b0; start = 1'b1; flush = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    run("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulh",   3'd1, MINV,         MINV,          32'h4000_0000);
    run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run("divu",   3'd5, 32'd100,      32'd7,         32'd14);
    run("remu",   3'd7, 32'd100,      32'd7,         32'd2);
    run("divu0",  3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF);
    run("remu0",  3'd7, 32'd5,        32'd0,         32'd5);
    run("divovf", 3'd4, MINV,         32'hFFFF_FFFF, MINV);
    run("removf", 3'd6, MINV,         32'hFFFF_FFFF, 32'd0);
    run("divu_pre", 3'd5, 32'd100,    32'd7,         32'd14);

    // flush mid-DIV, with start still high in the following IDLE
    prior = 32'd14;
    begin_op(3'd4, 32'd1000, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    start = 1'b0; flush = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush_idle_busy", 64'(busy), 64'd0);
      chk("flush_idle_done", 64'(done), 64'd0);
    end
    chk("flush_keep", 64'(result), 64'(prior));

    // reset during a MUL
    begin_op(3'd0, 32'd3, 32'd5);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    // back-to-back MULs with start held through done
    begin_op(3'd0, 32'd1234, 32'd5678);
    wait_done("b2b_a", 33, model(3'd0, 32'd1234, 32'd5678), 1'b0);
    @(negedge clk);
    rs1_data = 32'hFFFF_FF00; rs2_data = 32'd300;
    @(posedge clk); #1;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done("b2b_b", 33, model(3'd0, 32'hFFFF_FF00, 32'd300), 1'b1);

    for (int i = 0; i < 32; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = MINV; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      run($sformatf("rnd%0d_op%0d", i, f), f, a, b, model(f, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine and sequencer, instantiated beside the ALU in the execute stage.
- Accepts one M-extension op from EX and holds the pipeline through a stall output while it runs an XLEN-step shift-add or restoring-divide sequence.
- Returns the result with a one-cycle done pulse for the EX/MEM register.
- Handles RISC-V divide-by-zero and signed-overflow corner cases via a single-cycle fast path.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-low; state cleared on rising clk while reset==0
start  input  1  EX holds an M-op (id_ex valid & is_muldiv); held high until done
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  forwarded rs1 (dividend / multiplicand)
rs2_data  input  XLEN  forwarded rs2 (divisor / multiplier)
flush  input  1  branch/jump flush; aborts the in-flight op
busy  output  1  stall request to hazard unit
done  output  1  one-cycle pulse; result valid
result  output  XLEN  op result, held until next accepted start

Behaviour:
- FSM states: IDLE, CALC, DONE.
- Reset (reset==0): state=IDLE, iteration counter=0, result=0, done=0, busy=0. Reset mid-CALC aborts with no done pulse.
- IDLE, start=1, flush=0: latch op, operand magnitudes and result-sign flags; counter=0.
  - Normal path: next state CALC.
  - Fast path: divisor==0 for ops 1xx, or (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF). Next state DONE.
- busy = (IDLE & start & ~flush) | CALC. Combinational, so the instruction freezes in ID/EX in the same cycle it arrives. busy=0 in DONE.
- CALC:
  - One iteration per cycle; counter increments.
  - After the XLEN-th iteration (counter==XLEN-1), next state DONE.
  - Total latency: start cycle = 0, done at cycle XLEN+1 (33).
- Multiply:
  - Unsigned shift-add of magnitudes into a 2*XLEN product.
  - Signedness: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU unsigned.
  - Product is negated when the operand signs differ (signed operands only).
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Fast-path results:
  - Divide by zero: quotient=all ones, remainder=rs1.
  - Overflow: quotient=0x80000000, remainder=0.
- Result register is loaded on the transition into DONE.
- DONE: done=1 for exactly one cycle, start ignored; next state IDLE. EX advances because busy=0.
- A start still high in the following IDLE is a new op. The hazard unit guarantees ID/EX moved.
- flush=1 in any state: next state IDLE, no done, result unchanged. flush and start together in IDLE: op not accepted, busy=0.
- flush in DONE: done still pulses that cycle (already-committed result); next state IDLE.
- Any op value is legal; there is no error output.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (start at cycle 0) -> busy=1 cycles 0–32; done=1 at cycle 33; result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each done at cycle 33.
- Fast path, each done at cycle 1 with busy=1 only in cycle 0:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- flush=1 at cycle 10 of a DIV -> IDLE at cycle 11, busy=0, no done, result keeps the prior value. start+flush in the same IDLE cycle -> busy=0, not accepted.
- reset=0 at cycle 5 of a MUL -> next cycle result=0, done=0, busy=0. A back-to-back MUL issued right after a done completes with a correct, independent result.
